spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 116 +++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI slave with oversampled sclk: samples mosi on leading edges, shifts miso on trailing edges.
// Frame length is latched at the first leading edge; an inactivity timeout aborts stalled frames.
module spi_slave #(
  parameter int NB_MAX = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  input  logic              cpol,
  input  logic [7:0]        nb,
  input  logic [31:0]       n_idle,
  input  logic [NB_MAX-1:0] tx_data,
  output logic [NB_MAX-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic [2:0]        sclk_s;
  logic [1:0]        mosi_s;
  logic [NB_MAX-1:0] tx_sr;
  logic [NB_MAX-1:0] rx_sr;
  logic [7:0]        cnt;
  logic [7:0]        nb_lat;
  logic [31:0]       idle_cnt;

  logic              lead, trail;
  logic [7:0]        nb_eff;
  logic [NB_MAX-1:0] tx_first, tx_nxt, tx_nxt_sh;

  // Stage 1 vs stage 2 of the sclk pipe gives the edge; mosi_s[1] is aligned with sclk_s[1].
  assign lead  = (sclk_s[2] == cpol) && (sclk_s[1] != cpol);
  assign trail = (sclk_s[2] != cpol) && (sclk_s[1] == cpol);

  always_comb begin
    nb_eff    = (nb == 8'd0 || int'(nb) > NB_MAX) ? 8'(NB_MAX) : nb;
    tx_first  = tx_data >> (nb_eff - 8'd1);
    tx_nxt    = tx_sr << 1;
    tx_nxt_sh = tx_nxt >> (nb_lat - 8'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sclk_s    <= '0;
      mosi_s    <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      cnt       <= '0;
      nb_lat    <= '0;
      idle_cnt  <= '0;
      miso      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sclk_s    <= {sclk_s[1:0], sclk};
      mosi_s    <= {mosi_s[0], mosi};
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          tx_sr    <= tx_data;
          miso     <= tx_first[0];
          busy     <= 1'b0;
          idle_cnt <= '0;
          if (lead) begin
            nb_lat <= nb_eff;
            rx_sr  <= {{(NB_MAX-1){1'b0}}, mosi_s[1]};
            cnt    <= 8'd1;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (lead || trail) begin
            idle_cnt <= '0;
            // Extra leading edges past the frame length are dropped.
            if (lead && cnt < nb_lat) begin
              rx_sr <= {rx_sr[NB_MAX-2:0], mosi_s[1]};
              cnt   <= cnt + 8'd1;
            end
            if (trail) begin
              if (cnt < nb_lat) begin
                tx_sr <= tx_nxt;
                miso  <= tx_nxt_sh[0];
              end else begin
                state <= DONE;
              end
            end
          end else if (n_idle != 32'd0 && idle_cnt + 32'd1 == n_idle) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
        end
        DONE: begin
          rx_data  <= rx_sr;
          rx_valid <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
